// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, decode handshake and
// redirect/halt control from decode, plus the stop status flags.
interface fetch_unit_if;
    // Instruction memory request/response
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    // Control from decode
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;

    // Delivery to decode
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction;
    logic [31:0] pc;

    // Stop status
    logic        halted;
    logic        fault;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        input  halt,
        output out_valid,
        input  out_ready,
        output instruction,
        output pc,
        output halted,
        output fault
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        output halt,
        input  out_valid,
        output out_ready,
        input  instruction,
        input  pc,
        input  halted,
        input  fault
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, keeps up to FIFO_DEPTH word reads in
// flight, buffers returned words with their PCs and hands them to decode.
// Redirects flush buffered and in-flight fetches; halt or a misaligned
// redirect stops fetching until reset.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   aq_rd_ptr_q, aq_rd_ptr_d;
    logic [PTR_W-1:0]   aq_wr_ptr_q, aq_wr_ptr_d;
    logic               halted_q, halted_d;
    logic               fault_q, fault_d;

    // Instruction buffer (word + PC) and the PCs of in-flight requests
    logic [31:0]        fifo_instr_q [FIFO_DEPTH];
    logic [31:0]        fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]        aq_pc_q      [FIFO_DEPTH];

    logic               active_c;
    logic               out_valid_c;
    logic               pop_c;
    logic [SUM_W-1:0]   inflight_c;
    logic               imem_req_c;
    logic               accept_c;
    logic               halt_c;
    logic               redir_c;
    logic               misalign_c;
    logic               rsp_c;
    logic               push_c;

    // Per-cycle qualifiers: issue, accept, response, push/pop, stop events.
    always_comb begin
        active_c    = (state_q == ST_RUN) && !rst;
        out_valid_c = active_c && (count_q != '0) && !bus.redirect;
        pop_c       = out_valid_c && bus.out_ready;
        // Buffered plus in-flight words bound the request window.
        inflight_c  = SUM_W'(outstanding_q) + SUM_W'(count_q) - SUM_W'(pop_c);
        imem_req_c  = active_c && !bus.redirect && !bus.halt &&
                      (inflight_c < SUM_W'(FIFO_DEPTH));
        accept_c    = imem_req_c && bus.imem_ready;
        halt_c      = active_c && bus.halt;
        redir_c     = active_c && bus.redirect && !bus.halt;
        misalign_c  = redir_c && (bus.redirect_pc[1:0] != 2'b00);
        // A response with nothing outstanding is a protocol error and is ignored.
        rsp_c       = bus.imem_rvalid && (outstanding_q != '0);
        push_c      = rsp_c && (drop_cnt_q == '0) && active_c &&
                      !bus.redirect && !bus.halt;
    end

    // Next-state: FSM, PC, request accounting and buffer pointers.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        aq_rd_ptr_d   = aq_rd_ptr_q;
        aq_wr_ptr_d   = aq_wr_ptr_q;
        halted_d      = halted_q;
        fault_d       = fault_q;

        if (accept_c) begin
            pc_d        = pc_q + 32'd4;
            aq_wr_ptr_d = aq_wr_ptr_q + PTR_W'(1);
        end

        if (rsp_c) begin
            aq_rd_ptr_d = aq_rd_ptr_q + PTR_W'(1);
            if (drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
        outstanding_d = outstanding_q + CNT_W'(accept_c) - CNT_W'(rsp_c);

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        unique case (state_q)
            ST_RUN: begin
                if (halt_c || redir_c) begin
                    // Any stop or redirect discards the buffered words.
                    count_d  = '0;
                    rd_ptr_d = '0;
                    wr_ptr_d = '0;
                end
                if (halt_c) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end else if (misalign_c) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                    fault_d  = 1'b1;
                end else if (redir_c) begin
                    // Everything still in flight belongs to the old path.
                    pc_d       = bus.redirect_pc;
                    drop_cnt_d = outstanding_q - CNT_W'(rsp_c);
                end
            end
            ST_HALTED: begin
                // Only reset leaves; late responses are absorbed by rsp_c.
                state_d = ST_HALTED;
            end
            default: state_d = ST_HALTED;
        endcase
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            aq_rd_ptr_q   <= '0;
            aq_wr_ptr_q   <= '0;
            halted_q      <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            aq_rd_ptr_q   <= aq_rd_ptr_d;
            aq_wr_ptr_q   <= aq_wr_ptr_d;
            halted_q      <= halted_d;
            fault_q       <= fault_d;
        end
    end

    // Storage arrays: contents are only meaningful behind the valid pointers.
    always_ff @(posedge clk) begin
        if (accept_c) begin
            aq_pc_q[aq_wr_ptr_q] <= pc_q;
        end
        if (push_c) begin
            fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
            fifo_pc_q[wr_ptr_q]    <= aq_pc_q[aq_rd_ptr_q];
        end
    end

    // Output drive.
    always_comb begin
        bus.imem_req    = imem_req_c;
        bus.imem_addr   = pc_q;
        bus.out_valid   = out_valid_c;
        bus.instruction = fifo_instr_q[rd_ptr_q];
        bus.pc          = fifo_pc_q[rd_ptr_q];
        bus.halted      = halted_q;
        bus.fault       = fault_q;
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: in-order variable-latency memory model,
// scoreboard of expected (pc, word) deliveries, and directed redirect/halt cases.
module tb_fetch_unit;

    localparam int DEPTH = 2;
    localparam int BIG   = 1000000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          rel_cyc  = 0;
    mem_req_t    mem_q[$];
    logic [31:0] exp_q[$];
    int          mem_lat   = 1;
    int          ready_pct = 100;
    int          req_limit = BIG;
    int          acc_cnt = 0, del_cnt = 0, max_occ = 0;
    int          first_valid_cyc = -1, first_del_cyc = -1, last_del_cyc = -1;
    bit          occ_en   = 1'b0;
    bit          stop_chk = 1'b0;

    // Monitor scratch
    logic        m_acc, m_pop;
    int          m_occ;
    logic [31:0] m_exp;
    mem_req_t    m_req;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: responds in order, one word per cycle, mem_lat cycles after accept.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mem_q.delete();
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
        bus.imem_ready = (acc_cnt < req_limit) && ($urandom_range(0, 99) < ready_pct);
    end

    // Monitor: records accepts, scores deliveries, checks per-cycle invariants.
    always @(negedge clk) begin
        if (!rst) begin
            m_acc = bus.imem_req && bus.imem_ready;
            m_pop = bus.out_valid && bus.out_ready;
            if (bus.imem_req) check_eq("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            if (bus.redirect) check_eq("no_req_on_redirect", 32'(bus.imem_req), 32'd0);
            if (stop_chk) begin
                check_eq("stopped_req", 32'(bus.imem_req), 32'd0);
                check_eq("stopped_valid", 32'(bus.out_valid), 32'd0);
            end
            if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_acc) begin
                m_req.addr = bus.imem_addr;
                m_req.due  = cyc + mem_lat;
                mem_q.push_back(m_req);
            end
            if (m_pop) begin
                check_eq("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    m_exp = exp_q.pop_front();
                    check_eq("deliver_pc", bus.pc, m_exp);
                    check_eq("deliver_instr", bus.instruction, mem_word(m_exp));
                end
                if (first_del_cyc < 0) first_del_cyc = cyc;
                last_del_cyc = cyc;
            end
            m_occ = acc_cnt + int'(m_acc) - del_cnt - int'(m_pop);
            if (occ_en) check_eq("occ_le_depth", 32'(m_occ <= DEPTH), 32'd1);
            if (m_occ > max_occ) max_occ = m_occ;
            acc_cnt = acc_cnt + int'(m_acc);
            del_cnt = del_cnt + int'(m_pop);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input int lat, input int pct, input int lim, input bit occ);
        mem_lat   = lat;
        ready_pct = pct;
        req_limit = lim;
        occ_en    = occ;
    endtask

    // Two reset edges, reset-state checks, then release; returns in cycle r.
    task automatic do_reset();
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.out_ready   = 1'b0;
        stop_chk        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_halted", 32'(bus.halted), 32'd0);
        check_eq("rst_fault", 32'(bus.fault), 32'd0);
        acc_cnt         = 0;
        del_cnt         = 0;
        max_occ         = 0;
        first_valid_cyc = -1;
        first_del_cyc   = -1;
        last_del_cyc    = -1;
        tick();
        rst     = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        check_eq({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        bus.out_ready   = 1'b0;
        tick();

        // Latency-1 streaming from reset: back-to-back delivery.
        setup(1, 100, BIG, 1'b1);
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        do_reset();
        bus.out_ready = 1'b1;
        wait_drained("s1", 40);
        check_eq("s1_first_valid_lat", 32'(first_valid_cyc - rel_cyc), 32'd2);
        check_eq("s1_back_to_back", 32'(last_del_cyc - first_del_cyc), 32'd7);

        // Latency-3 with decode stalled for 5 cycles.
        setup(3, 100, BIG, 1'b1);
        for (int i = 0; i < 10; i++) exp_q.push_back(32'(i * 4));
        do_reset();
        bus.out_ready = 1'b1;
        repeat (4) tick();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        bus.out_ready = 1'b1;
        wait_drained("s2", 100);
        check_eq("s2_max_occ", 32'(max_occ), 32'(DEPTH));

        // Redirect with two requests in flight: both stale words dropped.
        setup(3, 100, BIG, 1'b0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i * 4));
        do_reset();
        tick();
        tick();
        check_eq("s3_inflight", 32'(mem_q.size()), 32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        bus.out_ready   = 1'b1;
        tick();
        bus.redirect = 1'b0;
        check_eq("s3_addr_after_redirect", bus.imem_addr, 32'h100);
        wait_drained("s3", 60);

        // Redirect coinciding with a response and a pending delivery.
        setup(1, 100, BIG, 1'b0);
        exp_q.push_back(32'h0);
        for (int i = 0; i < 4; i++) exp_q.push_back(32'h200 + 32'(i * 4));
        do_reset();
        bus.out_ready = 1'b1;
        repeat (3) tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h200;
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        check_eq("s4_req_next_cycle", 32'(bus.imem_req), 32'd1);
        check_eq("s4_addr_next_cycle", bus.imem_addr, 32'h200);
        tick();
        wait_drained("s4", 40);

        // Halt with one request outstanding.
        setup(3, 100, 1, 1'b0);
        do_reset();
        bus.out_ready = 1'b1;
        tick();
        check_eq("s5_inflight", 32'(mem_q.size()), 32'd1);
        bus.halt = 1'b1;
        stop_chk = 1'b1;
        @(negedge clk);
        check_eq("s5_halted_not_yet", 32'(bus.halted), 32'd0);
        tick();
        check_eq("s5_halted", 32'(bus.halted), 32'd1);
        check_eq("s5_fault", 32'(bus.fault), 32'd0);
        tick();
        bus.halt = 1'b0;
        repeat (8) tick();
        check_eq("s5_outstanding_zero", 32'(dut.outstanding_q), 32'd0);
        check_eq("s5_still_halted", 32'(bus.halted), 32'd1);
        stop_chk = 1'b0;

        // Misaligned redirect target.
        setup(1, 100, BIG, 1'b0);
        do_reset();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h102;
        stop_chk        = 1'b1;
        tick();
        bus.redirect = 1'b0;
        check_eq("s6_halted", 32'(bus.halted), 32'd1);
        check_eq("s6_fault", 32'(bus.fault), 32'd1);
        repeat (8) tick();
        stop_chk = 1'b0;

        // Halt and misaligned redirect together: halt wins, no fault.
        setup(1, 100, BIG, 1'b0);
        do_reset();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h102;
        bus.halt        = 1'b1;
        stop_chk        = 1'b1;
        tick();
        bus.redirect = 1'b0;
        bus.halt     = 1'b0;
        check_eq("s7_halted", 32'(bus.halted), 32'd1);
        check_eq("s7_fault", 32'(bus.fault), 32'd0);
        repeat (6) tick();
        stop_chk = 1'b0;

        // PC wraps from 32'hFFFF_FFFC to 0.
        setup(1, 100, BIG, 1'b0);
        exp_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0004);
        exp_q.push_back(32'h0000_0008);
        do_reset();
        tick();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFF8;
        bus.out_ready   = 1'b1;
        tick();
        bus.redirect = 1'b0;
        check_eq("s8_addr_after_redirect", bus.imem_addr, 32'hFFFF_FFF8);
        wait_drained("s8", 40);

        // Random memory stalls and decode back-pressure.
        setup(2, 60, BIG, 1'b1);
        for (int i = 0; i < 24; i++) exp_q.push_back(32'(i * 4));
        do_reset();
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        bus.out_ready = 1'b0;
        check_eq("s9_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
